// File: rtl/mat_mult_2x2.sv
// mat_mult_2x2 -- pipelined 2x2 matrix multiplier, C = A x B.
//
// Three register stages: operand capture, product, sum. A new operand set is
// accepted every cycle; results appear after the third rising edge.
// Products are formed at full 32-bit width (zero- or sign-extended by
// SIGNED_MODE) and each element's two products are summed modulo 2^32.
//
// Parameters
//   SIGNED_MODE : 0 = unsigned operands/products, 1 = two's complement
// Ports
//   clk                 : clock, rising edge
//   rst                 : asynchronous reset, active low
//   a00,a01,a10,a11     : matrix A elements, 16 bit, [row][col]
//   b00,b01,b10,b11     : matrix B elements, 16 bit, [row][col]
//   c00,c01,c10,c11     : registered result elements, 32 bit
module mat_mult_2x2 #(
  parameter int SIGNED_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a00,
  input  logic [15:0] a01,
  input  logic [15:0] a10,
  input  logic [15:0] a11,
  input  logic [15:0] b00,
  input  logic [15:0] b01,
  input  logic [15:0] b10,
  input  logic [15:0] b11,
  output logic [31:0] c00,
  output logic [31:0] c01,
  output logic [31:0] c10,
  output logic [31:0] c11
);

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  // Full-width product; only the extension of the operands depends on the
  // mode, the low 32 bits of the product are then identical for both.
  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [ACC_W-1:0] xs;
    logic signed [ACC_W-1:0] ys;
    if (SIGNED_MODE != 0) begin
      xs = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x};
      ys = {{(ACC_W-DATA_W){y[DATA_W-1]}}, y};
    end else begin
      xs = {{(ACC_W-DATA_W){1'b0}}, x};
      ys = {{(ACC_W-DATA_W){1'b0}}, y};
    end
    return xs * ys;
  endfunction

  // Sum modulo 2^32: the carry out is intentionally dropped.
  function automatic logic [ACC_W-1:0] add_wrap(input logic [ACC_W-1:0] x,
                                                input logic [ACC_W-1:0] y);
    return x + y;
  endfunction

  logic [DATA_W-1:0] a_p0 [4];
  logic [DATA_W-1:0] b_p0 [4];
  logic [ACC_W-1:0]  prod_p1 [8];
  logic [ACC_W-1:0]  sum_p2 [4];

  // Stage p0: capture operands ([0]=x00, [1]=x01, [2]=x10, [3]=x11)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        a_p0[i] <= '0;
        b_p0[i] <= '0;
      end
    end else begin
      a_p0[0] <= a00;
      a_p0[1] <= a01;
      a_p0[2] <= a10;
      a_p0[3] <= a11;
      b_p0[0] <= b00;
      b_p0[1] <= b01;
      b_p0[2] <= b10;
      b_p0[3] <= b11;
    end
  end

  // Stage p1: eight products, paired per output element (2k, 2k+1 -> c[k])
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) prod_p1[i] <= '0;
    end else begin
      prod_p1[0] <= mul_ext(a_p0[0], b_p0[0]);
      prod_p1[1] <= mul_ext(a_p0[1], b_p0[2]);
      prod_p1[2] <= mul_ext(a_p0[0], b_p0[1]);
      prod_p1[3] <= mul_ext(a_p0[1], b_p0[3]);
      prod_p1[4] <= mul_ext(a_p0[2], b_p0[0]);
      prod_p1[5] <= mul_ext(a_p0[3], b_p0[2]);
      prod_p1[6] <= mul_ext(a_p0[2], b_p0[1]);
      prod_p1[7] <= mul_ext(a_p0[3], b_p0[3]);
    end
  end

  // Stage p2: element sums, driven straight to the outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) sum_p2[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) sum_p2[i] <= add_wrap(prod_p1[2*i], prod_p1[2*i+1]);
    end
  end

  assign c00 = sum_p2[0];
  assign c01 = sum_p2[1];
  assign c10 = sum_p2[2];
  assign c11 = sum_p2[3];

endmodule

// File: tb/tb_mat_mult_2x2.sv
// Bench for mat_mult_2x2: one unsigned and one signed instance share the same
// operands. Expected results come from a plain-arithmetic matrix product of
// the operand set sampled two edges earlier.
module tb_mat_mult_2x2;

  logic        clk;
  logic        rst;
  logic [15:0] a00, a01, a10, a11, b00, b01, b10, b11;
  logic [31:0] u00, u01, u10, u11;
  logic [31:0] s00, s01, s10, s11;

  int tests = 0;
  int fails = 0;

  // Operand sets sampled by the DUTs, newest first.
  logic [127:0] hist[$];

  mat_mult_2x2 #(.SIGNED_MODE(0)) u_uns (
    .clk(clk), .rst(rst),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .c00(u00), .c01(u01), .c10(u10), .c11(u11)
  );

  mat_mult_2x2 #(.SIGNED_MODE(1)) u_sgn (
    .clk(clk), .rst(rst),
    .a00(a00), .a01(a01), .a10(a10), .a11(a11),
    .b00(b00), .b01(b01), .b10(b10), .b11(b11),
    .c00(s00), .c01(s01), .c10(s10), .c11(s11)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint elem(input logic [15:0] x, input bit sm);
    if (sm) return longint'($signed(x));
    return longint'(x);
  endfunction

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j], reduced to 32 bits.
  function automatic logic [31:0] ref_c(input logic [127:0] v, input bit sm,
                                        input int i, input int j);
    logic [15:0] a [2][2];
    logic [15:0] b [2][2];
    longint acc;
    a[0][0] = v[127:112]; a[0][1] = v[111:96]; a[1][0] = v[95:80]; a[1][1] = v[79:64];
    b[0][0] = v[63:48];   b[0][1] = v[47:32];  b[1][0] = v[31:16]; b[1][1] = v[15:0];
    acc = 0;
    for (int k = 0; k < 2; k++) acc += elem(a[i][k], sm) * elem(b[k][j], sm);
    return acc[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    logic [31:0] e [2][8];
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 4; n++)
        e[m][n] = (hist.size() >= 3) ? ref_c(hist[2], m[0], n / 2, n % 2) : 32'd0;
    chk({tag, ".u00"}, u00, e[0][0]);
    chk({tag, ".u01"}, u01, e[0][1]);
    chk({tag, ".u10"}, u10, e[0][2]);
    chk({tag, ".u11"}, u11, e[0][3]);
    chk({tag, ".s00"}, s00, e[1][0]);
    chk({tag, ".s01"}, s01, e[1][1]);
    chk({tag, ".s10"}, s10, e[1][2]);
    chk({tag, ".s11"}, s11, e[1][3]);
  endtask

  task automatic set_in(input logic [15:0] x00, x01, x10, x11,
                        input logic [15:0] y00, y01, y10, y11);
    a00 = x00; a01 = x01; a10 = x10; a11 = x11;
    b00 = y00; b01 = y01; b10 = y10; b11 = y11;
  endtask

  task automatic set_rand();
    set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  // One rising edge: record what was sampled, then check just after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) begin
      hist.push_front({a00, a01, a10, a11, b00, b01, b10, b11});
      if (hist.size() > 3) void'(hist.pop_back());
    end
    #1;
    chk_all(tag);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".u00"}, u00, 32'd0); chk({tag, ".u11"}, u11, 32'd0);
    chk({tag, ".s00"}, s00, 32'd0); chk({tag, ".s11"}, s11, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    set_rand();
    #2;
    chk_zero("reset_async");
    // Reset held with clock running and random inputs.
    for (int i = 0; i < 4; i++) begin
      set_rand();
      @(posedge clk); #1;
      chk_zero("reset_hold");
    end
    // Release between edges.
    @(negedge clk);
    rst = 1'b1;

    // Basic product held for 22 edges.
    set_in(1, 2, 3, 4, 5, 6, 7, 8);
    for (int i = 0; i < 22; i++) tick("basic");
    chk("basic_c00", u00, 32'd19); chk("basic_c01", u01, 32'd22);
    chk("basic_c10", u10, 32'd43); chk("basic_c11", u11, 32'd50);

    // Wrap: all operands 0xFFFF.
    set_in(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 3; i++) tick("wrap");
    chk("wrap_uns", u10, 32'hFFFC0002);
    chk("wrap_sgn", s01, 32'd2);

    // Back-to-back sets.
    set_in(1, 2, 3, 4, 5, 6, 7, 8);
    tick("pipe");
    set_in(1, 0, 0, 1, 9, 10, 11, 12);
    tick("pipe");
    tick("pipe");
    chk("pipe_first_c11", u11, 32'd50);
    tick("pipe");
    chk("pipe_second_c00", u00, 32'd9);
    chk("pipe_second_c11", u11, 32'd12);

    // Signed operands.
    set_in(16'hFFFF, 2, 3, 16'hFFFC, 5, 16'hFFFA, 7, 8);
    for (int i = 0; i < 3; i++) tick("signed");
    chk("signed_c00", s00, 32'd9);
    chk("signed_c01", s01, 32'd22);
    chk("signed_c10", s10, 32'hFFFFFFF3);
    chk("signed_c11", s11, 32'hFFFFFFCE);

    // Random operand stream, a new set every edge.
    for (int i = 0; i < 40; i++) begin
      set_rand();
      tick("random");
    end

    // Reset pulse while the basic set is in flight.
    set_in(1, 2, 3, 4, 5, 6, 7, 8);
    tick("midrst_pre");
    tick("midrst_pre");
    #2;
    rst = 1'b0;
    hist.delete();
    #1;
    chk_zero("midrst_drop");
    @(negedge clk);
    rst = 1'b1;
    tick("midrst_after");
    chk("midrst_zero1", u00, 32'd0);
    tick("midrst_after");
    chk("midrst_zero2", u11, 32'd0);
    tick("midrst_after");
    chk("midrst_result", u11, 32'd50);
    for (int i = 0; i < 3; i++) tick("midrst_hold");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
